// File: rtl/booth_acc_pkg.sv
// Shared definitions for the booth_acc signed accumulation stage.
// Holds the state encoding, the default widths and the saturation limits
// used when the design is built with BOOTH_ACC_SAT_EN defined.
package booth_acc_pkg;

   localparam int PROD_W_DEF    = 15;
   localparam int ACC_W_DEF     = 16;
   localparam int MAX_TERMS_DEF = 8;

   // Clamp limits for the default accumulator width
   localparam logic [ACC_W_DEF-1:0] ACC_SAT_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
   localparam logic [ACC_W_DEF-1:0] ACC_SAT_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } booth_acc_state_t;

endpackage

// File: rtl/booth_acc_add.sv
// Combinational sign-extended adder for booth_acc.
// Adds a PROD_W-bit signed product to an ACC_W-bit signed accumulator in
// ACC_W+1 bits and flags results outside the ACC_W signed range.
// BOOTH_ACC_SAT_EN defined: out-of-range sums clamp to the signed limits.
// BOOTH_ACC_SAT_EN undefined: sums wrap to ACC_W bits.
module booth_acc_add
   import booth_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] acc_ext;
   logic [ACC_W:0] prod_ext;
   logic [ACC_W:0] sum_ext;

   assign acc_ext  = {acc[ACC_W-1], acc};
   assign prod_ext = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
   assign sum_ext  = acc_ext + prod_ext;

   // The extra top bit disagreeing with the ACC_W sign bit means out of range
   assign ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

`ifdef BOOTH_ACC_SAT_EN
   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // Clamp toward the side indicated by the true (wide) sign
   always_comb begin
      sum = sum_ext[ACC_W-1:0];
      if (ovf) begin
         sum = sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
      end
   end
`else
   assign sum = sum_ext[ACC_W-1:0];
`endif

endmodule

// File: rtl/booth_acc.sv
// booth_acc: sums one vector of signed Booth products (valid/ready in,
// held valid/ready out) and reports sum, term count and sticky overflow.
// Build option: define BOOTH_ACC_SAT_EN for saturating accumulation,
// otherwise the accumulator wraps in two's complement.
module booth_acc
   import booth_acc_pkg::*;
#(
   parameter int PROD_W    = PROD_W_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int MAX_TERMS = MAX_TERMS_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [PROD_W-1:0]              in_prod,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ACC_W-1:0]               out_acc,
   output logic [$clog2(MAX_TERMS+1)-1:0] out_count,
   output logic                           out_ovf
);

   localparam int CNT_W = $clog2(MAX_TERMS+1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);

   booth_acc_state_t state, state_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic [CNT_W-1:0] count, count_n;
   logic             ovf, ovf_n;
   logic             beat;
   logic [ACC_W-1:0] add_base;
   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;

   // A held result only blocks input until downstream takes it
   assign in_ready = (state != ST_DONE) || out_ready;
   assign beat     = in_valid && in_ready;

   // A new vector starts from zero; only a partial sum is carried forward
   assign add_base = (state == ST_ACC) ? acc : '0;

   booth_acc_add #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_add (
      .acc  (add_base),
      .prod (in_prod),
      .sum  (add_sum),
      .ovf  (add_ovf)
   );

   // Next-state and datapath update for the IDLE / ACC / DONE sequence
   always_comb begin
      state_n = state;
      acc_n   = acc;
      count_n = count;
      ovf_n   = ovf;
      unique case (state)
         ST_IDLE: begin
            if (beat) begin
               acc_n   = add_sum;
               count_n = CNT_ONE;
               ovf_n   = add_ovf;
               state_n = in_last ? ST_DONE : ST_ACC;
            end
         end
         ST_ACC: begin
            if (beat) begin
               acc_n   = add_sum;
               count_n = count + CNT_ONE;
               ovf_n   = ovf | add_ovf;
               state_n = (in_last || (count_n == CNT_MAX)) ? ST_DONE : ST_ACC;
            end
         end
         ST_DONE: begin
            if (beat) begin
               acc_n   = add_sum;
               count_n = CNT_ONE;
               ovf_n   = add_ovf;
               state_n = in_last ? ST_DONE : ST_ACC;
            end else if (out_ready) begin
               acc_n   = '0;
               count_n = '0;
               ovf_n   = 1'b0;
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State and result registers; out_valid is registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         count     <= count_n;
         ovf       <= ovf_n;
         out_valid <= (state_n == ST_DONE);
      end
   end

   assign out_acc   = acc;
   assign out_count = count;
   assign out_ovf   = ovf;

endmodule

// File: tb/tb_booth_acc.sv
// Self-checking bench for booth_acc: table of directed vectors plus
// hand-written stall, back-to-back and mid-vector reset sequences.
// Expected sums follow BOOTH_ACC_SAT_EN the same way the design does.
module tb_booth_acc;

   localparam int PROD_W    = 15;
   localparam int ACC_W     = 16;
   localparam int MAX_TERMS = 8;
   localparam int CNT_W     = 4;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string             name;
      int                n;
      bit                last;
      logic [7:0][14:0]  prods;
      logic [15:0]       acc;
      logic [3:0]        cnt;
      logic              ovf;
   } vec_t;

   vec_t vecs[8];

   booth_acc #(
      .PROD_W    (PROD_W),
      .ACC_W     (ACC_W),
      .MAX_TERMS (MAX_TERMS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global bound so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input string name, input int n, input bit last,
                               input int p[8], input int acc, input int cnt, input bit ovf);
      vec_t v;
      int   t;
      v.name = name;
      v.n    = n;
      v.last = last;
      for (int i = 0; i < 8; i++) begin
         t = p[i];
         v.prods[i] = t[14:0];
      end
      t     = acc;
      v.acc = t[15:0];
      t     = cnt;
      v.cnt = t[3:0];
      v.ovf = ovf;
      return v;
   endfunction

   task automatic apply_stimulus(input vec_t v);
      out_ready = 1'b1;
      for (int i = 0; i < v.n; i++) begin
         in_valid = 1'b1;
         in_prod  = v.prods[i];
         in_last  = v.last && (i == v.n - 1);
         #1;
         check_output({v.name, "/in_ready"}, 32'(in_ready), 32'd1);
         tick();
         if (i < v.n - 1) begin
            check_output({v.name, "/valid_mid"}, 32'(out_valid), 32'd0);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_output({v.name, "/valid"}, 32'(out_valid), 32'd1);
      check_output({v.name, "/acc"},   32'(out_acc),   32'(v.acc));
      check_output({v.name, "/count"}, 32'(out_count), 32'(v.cnt));
      check_output({v.name, "/ovf"},   32'(out_ovf),   32'(v.ovf));
      tick();
      check_output({v.name, "/pulse"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      vecs[0] = mk("basic", 3, 1'b1, '{100, -30, 7, 0, 0, 0, 0, 0}, 77, 3, 1'b0);
      vecs[1] = mk("single", 1, 1'b1, '{16383, 0, 0, 0, 0, 0, 0, 0}, 16383, 1, 1'b0);
`ifdef BOOTH_ACC_SAT_EN
      vecs[2] = mk("forced8", 8, 1'b0, '{16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383}, 32767, 8, 1'b1);
      vecs[3] = mk("negovf", 3, 1'b1, '{-16384, -16384, -16384, 0, 0, 0, 0, 0}, -32768, 3, 1'b1);
      vecs[4] = mk("recover", 5, 1'b1, '{16383, 16383, 16383, -16384, -16384, 0, 0, 0}, -1, 5, 1'b1);
`else
      vecs[2] = mk("forced8", 8, 1'b0, '{16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383}, -8, 8, 1'b1);
      vecs[3] = mk("negovf", 3, 1'b1, '{-16384, -16384, -16384, 0, 0, 0, 0, 0}, 16384, 3, 1'b1);
      vecs[4] = mk("recover", 5, 1'b1, '{16383, 16383, 16383, -16384, -16384, 0, 0, 0}, 16381, 5, 1'b1);
`endif
      vecs[5] = mk("negpair", 2, 1'b1, '{-1, -1, 0, 0, 0, 0, 0, 0}, -2, 2, 1'b0);
      vecs[6] = mk("last8", 8, 1'b1, '{1, 1, 1, 1, 1, 1, 1, 1}, 8, 8, 1'b0);
      vecs[7] = mk("minmax", 2, 1'b1, '{-16384, 16383, 0, 0, 0, 0, 0, 0}, -1, 2, 1'b0);

      // Reset state
      #2 rst_n = 1'b0;
      repeat (3) tick();
      check_output("rst/valid", 32'(out_valid), 32'd0);
      check_output("rst/acc",   32'(out_acc),   32'd0);
      check_output("rst/count", 32'(out_count), 32'd0);
      check_output("rst/ovf",   32'(out_ovf),   32'd0);
      check_output("rst/ready", 32'(in_ready),  32'd1);
      rst_n = 1'b1;
      tick();

      // Table-driven vectors
      for (int k = 0; k < 8; k++) begin
         apply_stimulus(vecs[k]);
      end

      // Result held while downstream stalls, then retire with same-cycle accept
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_prod   = 15'd10;
      tick();
      in_prod = 15'd20;
      in_last = 1'b1;
      tick();
      in_prod = 15'd5;
      in_last = 1'b0;
      #1;
      check_output("stall/ready0", 32'(in_ready), 32'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         check_output("stall/ready", 32'(in_ready),  32'd0);
         check_output("stall/valid", 32'(out_valid), 32'd1);
         check_output("stall/acc",   32'(out_acc),   32'd30);
         check_output("stall/count", 32'(out_count), 32'd2);
      end
      out_ready = 1'b1;
      #1;
      check_output("stall/release", 32'(in_ready), 32'd1);
      tick();
      check_output("stall/retired", 32'(out_valid), 32'd0);
      in_prod = 15'd6;
      in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_output("stall/next_valid", 32'(out_valid), 32'd1);
      check_output("stall/next_acc",   32'(out_acc),   32'd11);
      check_output("stall/next_count", 32'(out_count), 32'd2);
      tick();

      // Back-to-back vectors {1,2} and {3,4} with no bubble
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_prod   = 15'd1;
      in_last   = 1'b0;
      tick();
      in_prod = 15'd2;
      in_last = 1'b1;
      tick();
      check_output("b2b/valid1", 32'(out_valid), 32'd1);
      check_output("b2b/acc1",   32'(out_acc),   32'd3);
      check_output("b2b/count1", 32'(out_count), 32'd2);
      in_prod = 15'd3;
      in_last = 1'b0;
      #1;
      check_output("b2b/ready", 32'(in_ready), 32'd1);
      tick();
      check_output("b2b/gap", 32'(out_valid), 32'd0);
      in_prod = 15'd4;
      in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_output("b2b/valid2", 32'(out_valid), 32'd1);
      check_output("b2b/acc2",   32'(out_acc),   32'd7);
      check_output("b2b/count2", 32'(out_count), 32'd2);
      tick();

      // Reset after 2 of 4 beats discards the partial vector
      in_valid = 1'b1;
      in_prod  = 15'd9;
      in_last  = 1'b0;
      repeat (2) tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_output("abort/valid", 32'(out_valid), 32'd0);
      check_output("abort/count", 32'(out_count), 32'd0);
      check_output("abort/acc",   32'(out_acc),   32'd0);
      tick();
      check_output("abort/hold", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      tick();
      apply_stimulus(mk("after_rst", 2, 1'b1, '{5, 5, 0, 0, 0, 0, 0, 0}, 10, 2, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
